cnt24_down: RTL and testbench

- BCD hours stage (00-23) for the countdown-timer chain.
- Mirror of the up-counting 24-hour stage: it consumes a borrow from the minutes stage instead of a carry, and decrements.
- It also supports set-mode increment and decrement, and a parallel BCD preload for the timer start value.
- It sits above the minutes down-counter; BORROW_out feeds the expiry/day logic.

---
 rtl/clock_pkg.sv | 17 +
 rtl/bcd_hour_step.sv | 48 ++++
 rtl/cnt24_down.sv | 81 ++++++++
 tb/tb_cnt24_down.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants for the BCD clock/timer chain: mode bit indices,
// hour digit limits and the step direction type.
package clock_pkg;

  localparam int SCS_RUN = 0;
  localparam int SCS_SET = 1;

  localparam logic [3:0] HOUR_MAX_TENS = 4'd2;
  localparam logic [3:0] HOUR_MAX_ONES = 4'd3;
  localparam logic [3:0] DIGIT_MAX     = 4'd9;

  typedef enum logic {
    DIR_DEC = 1'b0,
    DIR_INC = 1'b1
  } step_dir_e;

endpackage

// File: rtl/bcd_hour_step.sv
// Combinational next value of a BCD hour pair (00-23), one step up or down.
// at_bound flags the value the step wraps from: 23 going up, 00 going down.
module bcd_hour_step
  import clock_pkg::*;
(
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  step_dir_e  dir,
  input  logic       wrap_en,
  output logic [3:0] next_tens,
  output logic [3:0] next_ones,
  output logic       at_bound
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next_tens = tens;
    next_ones = ones;
    at_bound  = 1'b0;
    if (dir == DIR_INC) begin
      at_bound = (tens == HOUR_MAX_TENS) && (ones == HOUR_MAX_ONES);
      if (at_bound) begin
        next_tens = 4'd0;
        next_ones = 4'd0;
      end else if (ones == DIGIT_MAX) begin
        next_tens = tens + 4'd1;
        next_ones = 4'd0;
      end else begin
        next_ones = ones + 4'd1;
      end
    end else begin
      at_bound = (tens == 4'd0) && (ones == 4'd0);
      if (at_bound) begin
        // Without wrap the pair saturates at 00.
        if (wrap_en) begin
          next_tens = HOUR_MAX_TENS;
          next_ones = HOUR_MAX_ONES;
        end
      end else if (ones != 4'd0) begin
        next_ones = ones - 4'd1;
      end else begin
        next_tens = tens - 4'd1;
        next_ones = DIGIT_MAX;
      end
    end
  end

endmodule

// File: rtl/cnt24_down.sv
// BCD hours down-counter (00-23) for the countdown timer: run-mode borrow
// decrement, set-mode inc/dec adjust and validated parallel preload.
module cnt24_down
  import clock_pkg::*;
#(
  parameter bit WRAP_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic       BORROW_in,
  input  logic [1:0] SET_CURRENT_STATE,
  input  logic       INC_MODE,
  input  logic       DEC_MODE,
  input  logic       LOAD,
  input  logic [3:0] LOAD_TENS,
  input  logic [3:0] LOAD_ONES,
  output logic [3:0] CNT3,
  output logic [3:0] CNT10,
  output logic       BORROW_out,
  output logic       ZERO,
  output logic       LOAD_ERR
);

  logic       run_step;
  logic       set_inc;
  logic       set_dec;
  logic       load_ok;
  step_dir_e  step_dir;
  logic       step_wrap;
  logic [3:0] step_tens;
  logic [3:0] step_ones;
  logic       step_at_bound;

  assign run_step = ENABLE & BORROW_in & SET_CURRENT_STATE[SCS_RUN];
  assign set_inc  = SET_CURRENT_STATE[SCS_SET] & INC_MODE & ~DEC_MODE;
  assign set_dec  = SET_CURRENT_STATE[SCS_SET] & DEC_MODE & ~INC_MODE;

  assign load_ok = (LOAD_TENS <= HOUR_MAX_TENS) && (LOAD_ONES <= DIGIT_MAX) &&
                   ({LOAD_TENS, LOAD_ONES} <= {HOUR_MAX_TENS, HOUR_MAX_ONES});

  // Set-mode decrement always wraps; only the run step honours WRAP_EN.
  assign step_dir  = set_inc ? DIR_INC : DIR_DEC;
  assign step_wrap = set_dec ? 1'b1 : WRAP_EN;

  bcd_hour_step u_step (
    .tens      (CNT3),
    .ones      (CNT10),
    .dir       (step_dir),
    .wrap_en   (step_wrap),
    .next_tens (step_tens),
    .next_ones (step_ones),
    .at_bound  (step_at_bound)
  );

  assign ZERO = (CNT3 == 4'd0) && (CNT10 == 4'd0);

  // When the stepper faces down its boundary flag is the zero detect.
  assign BORROW_out = run_step & WRAP_EN & (set_inc ? ZERO : step_at_bound);

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!RESET_N) begin
      CNT3     <= 4'd0;
      CNT10    <= 4'd0;
      LOAD_ERR <= 1'b0;
    end else begin
      LOAD_ERR <= LOAD & ~load_ok;
      if (LOAD) begin
        if (load_ok) begin
          CNT3  <= LOAD_TENS;
          CNT10 <= LOAD_ONES;
        end
      end else if (set_inc || set_dec || run_step) begin
        CNT3  <= step_tens;
        CNT10 <= step_ones;
      end
    end
  end

endmodule

// File: tb/tb_cnt24_down.sv
// Self-checking bench for cnt24_down: expected digit/error values are queued
// as stimulus is applied and compared once the clock edge has produced them.
module tb_cnt24_down;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       borrow_in;
  logic [1:0] scs;
  logic       inc_mode;
  logic       dec_mode;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;

  logic [3:0] cnt3, cnt10, nw_cnt3, nw_cnt10;
  logic       borrow_out, zero, load_err;
  logic       nw_borrow_out, nw_zero, nw_load_err;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic       nw_borrow_seen;

  always #5 clk = ~clk;

  cnt24_down #(.WRAP_EN(1'b1)) dut (
    .CLK(clk), .RESET_N(rst_n), .ENABLE(enable), .BORROW_in(borrow_in),
    .SET_CURRENT_STATE(scs), .INC_MODE(inc_mode), .DEC_MODE(dec_mode),
    .LOAD(load), .LOAD_TENS(load_tens), .LOAD_ONES(load_ones),
    .CNT3(cnt3), .CNT10(cnt10), .BORROW_out(borrow_out), .ZERO(zero),
    .LOAD_ERR(load_err)
  );

  cnt24_down #(.WRAP_EN(1'b0)) dut_nw (
    .CLK(clk), .RESET_N(rst_n), .ENABLE(enable), .BORROW_in(borrow_in),
    .SET_CURRENT_STATE(scs), .INC_MODE(inc_mode), .DEC_MODE(dec_mode),
    .LOAD(load), .LOAD_TENS(load_tens), .LOAD_ONES(load_ones),
    .CNT3(nw_cnt3), .CNT10(nw_cnt10), .BORROW_out(nw_borrow_out), .ZERO(nw_zero),
    .LOAD_ERR(nw_load_err)
  );

  task automatic idle_inputs();
    enable = 1'b0; borrow_in = 1'b0; scs = 2'b00;
    inc_mode = 1'b0; dec_mode = 1'b0;
    load = 1'b0; load_tens = 4'd0; load_ones = 4'd0;
  endtask

  // One clock with the currently driven inputs. BORROW_out is checked before
  // the edge; the queued digits/LOAD_ERR/ZERO are checked after it.
  task automatic step(input string name, input logic [7:0] exp_val,
                      input logic exp_err, input logic exp_borrow);
    logic [8:0] exp_entry;
    exp_q.push_back({exp_err, exp_val});
    @(negedge clk);
    nw_borrow_seen = nw_borrow_out;
    checks++;
    if (borrow_out !== exp_borrow) begin
      errors++;
      $display("FAIL %s borrow_out got %b want %b", name, borrow_out, exp_borrow);
    end
    @(posedge clk);
    #1;
    exp_entry = exp_q.pop_front();
    checks++;
    if ({cnt3, cnt10} !== exp_entry[7:0]) begin
      errors++;
      $display("FAIL %s digits got %h want %h", name, {cnt3, cnt10}, exp_entry[7:0]);
    end
    checks++;
    if (load_err !== exp_entry[8]) begin
      errors++;
      $display("FAIL %s load_err got %b want %b", name, load_err, exp_entry[8]);
    end
    checks++;
    if (zero !== (exp_entry[7:0] == 8'h00)) begin
      errors++;
      $display("FAIL %s zero got %b want %b", name, zero, exp_entry[7:0] == 8'h00);
    end
  endtask

  task automatic do_load(input string name, input logic [3:0] t, input logic [3:0] o,
                         input logic [7:0] exp_val, input logic exp_err);
    load = 1'b1; load_tens = t; load_ones = o;
    step(name, exp_val, exp_err, 1'b0);
    load = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    load = 1'b1; load_tens = 4'd1; load_ones = 4'd5;
    scs = 2'b10; inc_mode = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cnt3, cnt10, load_err} !== 9'h000) begin
      errors++;
      $display("FAIL reset state got %h/%b want 00/0", {cnt3, cnt10}, load_err);
    end
    checks++;
    if ({nw_cnt3, nw_cnt10, nw_load_err} !== 9'h000) begin
      errors++;
      $display("FAIL reset nowrap got %h/%b want 00/0", {nw_cnt3, nw_cnt10}, nw_load_err);
    end
    rst_n = 1'b1;
    idle_inputs();
    step("reset_release", 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_run_down();
    do_load("load_20", 4'd2, 4'd0, 8'h20, 1'b0);
    enable = 1'b1; borrow_in = 1'b1; scs = 2'b01;
    step("run_19", 8'h19, 1'b0, 1'b0);
    step("run_18", 8'h18, 1'b0, 1'b0);
    step("run_17", 8'h17, 1'b0, 1'b0);
    idle_inputs();
  endtask

  task automatic test_wrap();
    int h;
    logic [7:0] bcd;
    do_load("load_00", 4'd0, 4'd0, 8'h00, 1'b0);
    enable = 1'b1; borrow_in = 1'b1; scs = 2'b01;
    step("wrap_23", 8'h23, 1'b0, 1'b1);
    checks++;
    if (nw_borrow_seen !== 1'b0) begin
      errors++;
      $display("FAIL nowrap borrow got %b want 0", nw_borrow_seen);
    end
    checks++;
    if ({nw_cnt3, nw_cnt10} !== 8'h00 || nw_zero !== 1'b1) begin
      errors++;
      $display("FAIL nowrap hold got %h zero %b want 00 zero 1", {nw_cnt3, nw_cnt10}, nw_zero);
    end
    // Full day of run-mode borrows against an integer hour model.
    h = 23;
    for (int i = 0; i < 24; i++) begin
      logic b;
      b = (h == 0);
      h = (h == 0) ? 23 : h - 1;
      bcd = {4'(h / 10), 4'(h % 10)};
      step("run_day", bcd, 1'b0, b);
    end
    idle_inputs();
  endtask

  task automatic test_set_adjust();
    do_load("load_22", 4'd2, 4'd2, 8'h22, 1'b0);
    enable = 1'b1; borrow_in = 1'b1; scs = 2'b10;
    inc_mode = 1'b1;
    step("inc_23", 8'h23, 1'b0, 1'b0);
    step("inc_00", 8'h00, 1'b0, 1'b0);
    step("inc_01", 8'h01, 1'b0, 1'b0);
    inc_mode = 1'b0; dec_mode = 1'b1;
    step("dec_00", 8'h00, 1'b0, 1'b0);
    step("dec_23", 8'h23, 1'b0, 1'b0);
    step("dec_22", 8'h22, 1'b0, 1'b0);
    inc_mode = 1'b1;
    step("both_hold", 8'h22, 1'b0, 1'b0);
    // Both mode bits: adjust beats the run step.
    scs = 2'b11; dec_mode = 1'b0;
    step("set_over_run", 8'h23, 1'b0, 1'b0);
    idle_inputs();
  endtask

  task automatic test_load_err();
    do_load("rej_24", 4'd2, 4'd4, 8'h23, 1'b1);
    step("rej_24_clear", 8'h23, 1'b0, 1'b0);
    do_load("rej_30", 4'd3, 4'd0, 8'h23, 1'b1);
    step("rej_30_clear", 8'h23, 1'b0, 1'b0);
    do_load("rej_0a", 4'd0, 4'ha, 8'h23, 1'b1);
    do_load("acc_19", 4'd1, 4'd9, 8'h19, 1'b0);
    step("acc_19_hold", 8'h19, 1'b0, 1'b0);
    // A rejected load still blocks a concurrent run step.
    enable = 1'b1; borrow_in = 1'b1; scs = 2'b01;
    do_load("rej_over_run", 4'd2, 4'd9, 8'h19, 1'b1);
    idle_inputs();
  endtask

  task automatic test_load_priority();
    do_load("load_10", 4'd1, 4'd0, 8'h10, 1'b0);
    enable = 1'b1; borrow_in = 1'b1; scs = 2'b01;
    do_load("load_over_run", 4'd0, 4'd5, 8'h05, 1'b0);
    enable = 1'b0;
    step("enable_low", 8'h05, 1'b0, 1'b0);
    enable = 1'b1; scs = 2'b00;
    step("no_run_mode", 8'h05, 1'b0, 1'b0);
    scs = 2'b01;
    step("run_04", 8'h04, 1'b0, 1'b0);
    idle_inputs();
  endtask

  task automatic test_reset_mid_adjust();
    scs = 2'b10; inc_mode = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({cnt3, cnt10, load_err} !== 9'h000) begin
      errors++;
      $display("FAIL reset_mid_adjust got %h/%b want 00/0", {cnt3, cnt10}, load_err);
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_run_down();
    test_wrap();
    test_set_adjust();
    test_load_err();
    test_load_priority();
    test_reset_mid_adjust();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
